// File: rtl/mac_pkg.sv
// Shared definitions for the dot-product MAC datapath.
//   mac_state_t : controller states (IDLE, ACCUM, DONE)
//   PROD_W      : width of the 4x4 unsigned product from mult4
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } mac_state_t;

  localparam int unsigned PROD_W = 8;

  // Largest single product, used to bound the accumulator width.
  localparam int unsigned PROD_MAX = 225;

endpackage

// File: rtl/mult4.sv
// 4-bit unsigned array multiplier, purely combinational.
//   A : multiplicand (4 bits)
//   B : multiplier   (4 bits)
//   P : product      (8 bits)
module mult4
  import mac_pkg::*;
(
  input  logic [3:0]        A,
  input  logic [3:0]        B,
  output logic [PROD_W-1:0] P
);

  logic [PROD_W-1:0] pp  [4];
  logic [PROD_W-1:0] sum [4];

  // One row per multiplier bit: AND-gated multiplicand shifted into place,
  // then rippled down the array.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      pp[i] = PROD_W'(A & {4{B[i]}}) << i;
    end
    sum[0] = pp[0];
    for (int unsigned i = 1; i < 4; i++) begin
      sum[i] = sum[i-1] + pp[i];
    end
  end

  assign P = sum[3];

endmodule

// File: rtl/dot_product_mac4.sv
// Streaming dot-product engine built around mult4.
// Accepts VEC_LEN operand pairs over an in_valid/in_ready handshake,
// multiplies each registered pair, accumulates the products and presents the
// sum over an out_valid/out_ready handshake.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   clear     : synchronous abort of the partial vector (out_sum retained)
//   in_valid  : operand pair present
//   in_ready  : pair can be accepted this cycle
//   a, b      : 4-bit unsigned operands
//   out_valid : result present
//   out_ready : sink accepts the result
//   out_sum   : ACC_W-bit unsigned dot product
module dot_product_mac4
  import mac_pkg::*;
#(
  parameter int unsigned VEC_LEN = 4,
  parameter int unsigned ACC_W   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum
);

  localparam int unsigned CNT_W = $clog2(VEC_LEN + 1);

  if (VEC_LEN < 1 || VEC_LEN > 255) begin : g_bad_vec_len
    $error("dot_product_mac4: VEC_LEN must be 1..255");
  end

  // The full vector sum must fit without wrapping.
  if ((64'(VEC_LEN) * 64'(PROD_MAX)) >= (64'd1 << ACC_W)) begin : g_bad_acc_w
    $error("dot_product_mac4: ACC_W too narrow for VEC_LEN products");
  end

  mac_state_t        state;
  mac_state_t        state_next;
  logic              run_q;
  logic [3:0]        a_q;
  logic [3:0]        b_q;
  logic              v_q;
  logic [PROD_W-1:0] product;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  sum_next;
  logic [CNT_W-1:0]  in_cnt;
  logic              in_xfer;
  logic              out_xfer;
  logic              last_prod;

  mult4 u_mult4 (
    .A (a_q),
    .B (b_q),
    .P (product)
  );

  // run_q holds in_ready low while in reset and releases it on the first
  // edge afterwards; IDLE with in_cnt=0 alone would already say "ready".
  assign in_ready  = run_q && (state != DONE) && (in_cnt < CNT_W'(VEC_LEN));
  assign out_valid = (state == DONE);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign sum_next  = acc + ACC_W'(product);

  // Products come out in acceptance order, so the product in flight while
  // in_cnt already reads VEC_LEN is the last one of the vector.
  assign last_prod = v_q && (in_cnt == CNT_W'(VEC_LEN));

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (in_xfer)   state_next = ACCUM;
        ACCUM:   if (last_prod) state_next = DONE;
        DONE:    if (out_xfer)  state_next = IDLE;
        default:                state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      run_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      v_q     <= 1'b0;
      acc     <= '0;
      in_cnt  <= '0;
      out_sum <= '0;
    end else begin
      run_q <= 1'b1;
      state <= state_next;
      if (clear) begin
        v_q    <= 1'b0;
        acc    <= '0;
        in_cnt <= '0;
      end else begin
        v_q <= in_xfer;
        if (in_xfer) begin
          a_q    <= a;
          b_q    <= b;
          in_cnt <= in_cnt + 1'b1;
        end
        // in_ready is low in DONE, so a result transfer never coincides
        // with a pair transfer or a pending product.
        if (out_xfer) begin
          acc    <= '0;
          in_cnt <= '0;
        end else if (v_q) begin
          acc <= sum_next;
          if (last_prod) begin
            out_sum <= sum_next;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dot_product_mac4.sv
module tb_dot_product_mac4;

  localparam int unsigned VEC_LEN = 4;
  localparam int unsigned ACC_W   = 10;
  localparam int unsigned NV      = 20;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       a = '0;
  logic [3:0]       b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_sum;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  dot_product_mac4 #(
    .VEC_LEN (VEC_LEN),
    .ACC_W   (ACC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a pair and hold it until it transfers.
  task automatic send(input logic [3:0] av, input logic [3:0] bv);
    int unsigned k = 0;
    in_valid = 1'b1;
    a = av;
    b = bv;
    while (!in_ready && k < 100) begin
      tick();
      k++;
    end
    check("in_ready_wait", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  // Wait for out_valid (bounded) and return the presented sum without ticking.
  task automatic wait_result(output logic [31:0] s);
    int unsigned k = 0;
    while (!out_valid && k < 100) begin
      tick();
      k++;
    end
    check("out_valid_wait", out_valid, 1);
    s = 32'(out_sum);
  endtask

  // Back-to-back pairs, one per cycle, all with the same operands.
  task automatic burst(input logic [3:0] av, input logic [3:0] bv, input int unsigned n);
    in_valid = 1'b1;
    a = av;
    b = bv;
    for (int unsigned i = 0; i < n; i++) tick();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] s;
    logic [31:0] exp_q[$];
    logic [31:0] vsum;
    logic [31:0] held;
    logic        hold_prev;
    int unsigned pairs_sent;
    int unsigned pcnt;
    int unsigned rcv;
    int unsigned cyc;

    // Reset state
    repeat (3) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    rst_n = 1'b1;
    check("rst_release_in_ready", in_ready, 0);
    tick();
    check("post_rst_in_ready", in_ready, 1);

    // 1: back-to-back (15,15) x4, latency and one-cycle valid
    out_ready = 1'b1;
    burst(4'd15, 4'd15, 4);
    check("t1_valid_early", out_valid, 0);
    check("t1_in_ready_full", in_ready, 0);
    tick();
    check("t1_valid", out_valid, 1);
    check("t1_sum", out_sum, 900);
    tick();
    check("t1_valid_drop", out_valid, 0);
    check("t1_in_ready_again", in_ready, 1);

    // 2: gaps between pairs
    send(4'd3, 4'd5); repeat (2) tick();
    send(4'd2, 4'd7); repeat (2) tick();
    send(4'd0, 4'd9); repeat (2) tick();
    check("t2_no_early_result", out_valid, 0);
    send(4'd1, 4'd1);
    wait_result(s);
    check("t2_sum", s, 30);
    tick();

    // 3: sink back-pressure
    out_ready = 1'b0;
    burst(4'd1, 4'd1, 4);
    wait_result(s);
    for (int unsigned i = 0; i < 5; i++) begin
      check("t3_hold_valid", out_valid, 1);
      check("t3_hold_sum", out_sum, 4);
      check("t3_hold_in_ready", in_ready, 0);
      tick();
    end
    check("t3_still_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    check("t3_valid_drop", out_valid, 0);
    check("t3_in_ready_again", in_ready, 1);

    // 4: clear mid-vector, with a pair offered during the clear cycle
    in_valid = 1'b1;
    a = 4'd15;
    b = 4'd15;
    repeat (2) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    check("t4_in_ready", in_ready, 1);
    check("t4_out_valid", out_valid, 0);
    check("t4_sum_kept", out_sum, 4);
    burst(4'd2, 4'd2, 4);
    wait_result(s);
    check("t4_sum", s, 16);
    tick();

    // 5: asynchronous reset mid-vector
    burst(4'd1, 4'd1, 3);
    #3 rst_n = 1'b0;
    #1;
    check("t5_rst_in_ready", in_ready, 0);
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_out_sum", out_sum, 0);
    tick();
    rst_n = 1'b1;
    check("t5_release_in_ready", in_ready, 0);
    tick();
    check("t5_in_ready", in_ready, 1);
    burst(4'd1, 4'd1, 4);
    wait_result(s);
    check("t5_sum", s, 4);
    tick();
    check("t5_no_dup", out_valid, 0);

    // 6: random vectors against a scoreboard, random back-pressure
    pairs_sent = 0;
    pcnt = 0;
    rcv = 0;
    cyc = 0;
    vsum = 0;
    held = 0;
    hold_prev = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b0;
    while (rcv < NV && cyc < 5000) begin
      if (hold_prev) begin
        check("t6_hold_valid", out_valid, 1);
        check("t6_hold_sum", out_sum, held);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("t6_unexpected_result", out_sum, 32'hFFFF_FFFF);
        end else begin
          check("t6_sum", out_sum, exp_q.pop_front());
        end
        rcv++;
      end
      if (in_valid && in_ready) begin
        vsum += 32'(a) * 32'(b);
        pairs_sent++;
        pcnt++;
        if (pcnt == VEC_LEN) begin
          exp_q.push_back(vsum);
          vsum = 0;
          pcnt = 0;
        end
      end
      hold_prev = out_valid && !out_ready;
      held = 32'(out_sum);
      tick();
      cyc++;
      out_ready = 1'($urandom_range(1));
      in_valid = (pairs_sent < NV * VEC_LEN) && ($urandom_range(3) != 0);
      a = 4'($urandom_range(15));
      b = 4'($urandom_range(15));
    end
    in_valid = 1'b0;
    check("t6_result_count", rcv, NV);
    check("t6_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
